// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encoding
// and the counter-width helper.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Bit-step counter width: must be able to hold 0..width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 32'd1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single 1-bit full adder; the only arithmetic element of the sequencer.
module fa_cell (
  input  logic ai,
  input  logic bi,
  input  logic ci,
  output logic s,
  output logic co
);

  assign {co, s} = {1'b0, ai} + {1'b0, bi} + {1'b0, ci};

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: captures two WIDTH-bit operands and a carry,
// feeds one bit per cycle (LSB first) through a shared 1-bit full adder,
// and publishes {cout,sum} together with a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] s_msb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cell_s;
  logic             cell_c;

  fa_cell u_cell (
    .ai (a_sh[0]),
    .bi (b_sh[0]),
    .ci (carry),
    .s  (cell_s),
    .co (cell_c)
  );

  // Accumulator update: shift right and drop the new sum bit into the MSB
  // (written with a mask so WIDTH=1 needs no special slice).
  always_comb begin
    s_msb          = '0;
    s_msb[WIDTH-1] = cell_s;
    acc_nxt        = (acc >> 1'b1) | s_msb;
  end

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus busy/done flags, registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  // Operand capture, bit stepping and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          carry <= cell_c;
          a_sh  <= a_sh >> 1'b1;
          b_sh  <= b_sh >> 1'b1;
          acc   <= acc_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            sum  <= acc_nxt;
            cout <= cell_c;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1, using a
// timeline-level reference model (accept edge + fixed latency, result a+b+cin).
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, start1, cin1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, cout8, busy1, done1, cout1;
  logic [7:0] sum8;
  logic [0:0] sum1;

  int checks = 0;
  int errors = 0;

  // model state per DUT (0: WIDTH=8, 1: WIDTH=1)
  int cyc[2];
  int pend[2];
  int res[2];
  int edge_cnt = 0;
  int last_acc = -1;
  int acc_cnt  = 0;
  bit b2b      = 1'b0;
  bit chk_en   = 1'b0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a transaction accepted at edge k shows busy for W cycles,
  // then done for one cycle with {cout,sum}=a+b+cin, then idle.
  task automatic model_step(input int id, input int w, input logic st,
                            input int aa, input int bb, input logic ci);
    if (rst) begin
      cyc[id] = -1;
      res[id] = 0;
    end else if (cyc[id] < 0) begin
      if (st) begin
        cyc[id]  = 0;
        pend[id] = aa + bb + int'(ci);
        if (id == 0 && b2b) begin
          if (last_acc >= 0) check("b2b_spacing", edge_cnt - last_acc, 10);
          last_acc = edge_cnt;
          acc_cnt++;
        end
      end
    end else begin
      cyc[id]++;
      if (cyc[id] == w) res[id] = pend[id];
      else if (cyc[id] == w + 1) cyc[id] = -1;
    end
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    model_step(0, 8, start8, int'(a8), int'(b8), cin8);
    model_step(1, 1, start1, int'(a1), int'(b1), cin1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy8", busy8, (cyc[0] >= 0 && cyc[0] < 8));
      check("done8", done8, (cyc[0] == 8));
      check("res8", {cout8, sum8}, res[0][8:0]);
      check("busy1", busy1, (cyc[1] == 0));
      check("done1", done1, (cyc[1] == 1));
      check("res1", {cout1, sum1}, res[1][1:0]);
      check("busy_done_excl", busy8 & done8, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_add(input int id, input logic [7:0] aa, input logic [7:0] bb,
                         input logic ci, input logic [8:0] exp, input string nm);
    int n, bc, w;
    logic dn, bz;
    w = (id == 0) ? 8 : 1;
    if (id == 0) begin start8 = 1'b1; a8 = aa; b8 = bb; cin8 = ci; end
    else begin start1 = 1'b1; a1 = aa[0]; b1 = bb[0]; cin1 = ci; end
    tick();
    start8 = 1'b0;
    start1 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    n = 0; bc = 0; dn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dn = (id == 0) ? done8 : done1;
      bz = (id == 0) ? busy8 : busy1;
      if (bz) bc++;
      if (dn) break;
      tick();
      n++;
    end
    check({nm, "_done_seen"}, dn, 1'b1);
    check({nm, "_latency"}, n, w);
    check({nm, "_busy_cycles"}, bc, w);
    if (id == 0) check({nm, "_result"}, {cout8, sum8}, exp);
    else         check({nm, "_result"}, {cout1, sum1}, exp[1:0]);
    tick();
  endtask

  initial begin
    int d;
    int e;
    logic [2:0] v;
    logic [7:0] ra, rb;
    logic rc;
    rst = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  cin1 = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    check("reset_busy", busy8, 1'b0);
    check("reset_done", done8, 1'b0);
    check("reset_res", {cout8, sum8}, 9'h000);
    rst = 1'b0;
    tick();

    run_add(0, 8'h00, 8'h00, 1'b0, 9'h000, "zero");
    run_add(0, 8'hFF, 8'h01, 1'b0, 9'h100, "ff_01");
    run_add(0, 8'hFF, 8'hFF, 1'b1, 9'h1FF, "ff_ff_c");
    run_add(0, 8'h5A, 8'h3C, 1'b0, 9'h096, "5a_3c");

    // start during RUN is dropped
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    tick();
    start8 = 1'b0;
    d = 0;
    repeat (16) begin
      tick();
      if (done8) begin
        d++;
        check("drop_result", {cout8, sum8}, 9'h046);
      end
    end
    check("drop_done_count", d, 1);

    // reset in the 4th RUN cycle
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_res", {cout8, sum8}, 9'h000);
    rst = 1'b0;
    d = 0;
    repeat (12) begin
      tick();
      if (done8) d++;
    end
    check("rst_no_done", d, 0);
    run_add(0, 8'h5A, 8'h3C, 1'b0, 9'h096, "after_rst");

    // random single transactions
    repeat (8) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      e = int'(ra) + int'(rb) + int'(rc);
      run_add(0, ra, rb, rc, 9'(e), "rand");
    end

    // back-to-back with start held high
    last_acc = -1;
    acc_cnt  = 0;
    b2b      = 1'b1;
    start8   = 1'b1;
    repeat (200) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      tick();
    end
    start8 = 1'b0;
    b2b    = 1'b0;
    check("b2b_accepts", acc_cnt, 20);
    repeat (12) tick();

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      e = int'(v[2]) + int'(v[1]) + int'(v[0]);
      run_add(1, {7'd0, v[2]}, {7'd0, v[1]}, v[0], 9'(e), "w1");
    end
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
